kbd_event_scheduler: RTL and testbench
======================================

// Module: kbd_event_scheduler
// PURPOSE
//  Drains keyboard and mouse events from the Keyboard receiver's single-entry buffer
//  (data_ready / is_mouse_data / keyboard_data / keyboard_data_retrieved) into two queues.
//  Queues: one for keyboard events, one for mouse events.
//  Delivers the queued events to one downstream valid/ready consumer (monitor-bus packet sender).
//  Arbitration between the two queues is round-robin.
//  The receiver is never left stalled: every buffered event is acknowledged, even when it is dropped.
// PARAMETERS
//  KB_DEPTH   4   keyboard queue entries; power of two, >=2
//  MS_DEPTH   4   mouse queue entries; power of two, >=2
// PORTS
//  clk            in   1   monitor clock (same clock as Keyboard)
//  rst_n          in   1   asynchronous active-low reset
//  kb_data_ready  in   1   Keyboard.data_ready
//  kb_is_mouse    in   1   Keyboard.is_mouse_data; stable while kb_data_ready=1
//  kb_data        in   16  Keyboard.keyboard_data
//  kb_retrieved   out  1   to Keyboard.keyboard_data_retrieved; single-cycle pulse
//  out_valid      out  1   event available downstream
//  out_is_mouse   out  1   1 = mouse event, 0 = keyboard event
//  out_data       out  16  event payload
//  out_ready      in   1   downstream accepts when out_valid & out_ready
//  kb_level       out  3   keyboard queue occupancy (0..KB_DEPTH)
//  ms_level       out  3   mouse queue occupancy (0..MS_DEPTH)
//  kb_drop_cnt    out  8   keyboard events dropped (queue full); saturates at 255
//  ms_drop_cnt    out  8   mouse events dropped; saturates at 255
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - Outputs: kb_retrieved=0, out_valid=0, out_is_mouse=0, out_data=0.
//   - Levels and drop counters = 0; queue pointers = 0.
//   - Capture FSM -> IDLE; rr_last = 1 (mouse), so keyboard wins the first tie.
//   - Mid-operation reset discards all queued and in-flight events.
//  Capture FSM (IDLE, ACK, WAIT_LOW)
//   - IDLE: if kb_data_ready=1 at edge N, go to ACK.
//     In the same edge, write {kb_is_mouse, kb_data} into the selected queue if it has room.
//     Otherwise increment that queue's drop counter.
//   - ACK: kb_retrieved=1 for exactly this one cycle, then go to WAIT_LOW.
//   - WAIT_LOW: stay until kb_data_ready=0, then go to IDLE.
//     This guards against re-capturing the same event, because Keyboard clears data_ready one cycle after the ack.
//   - A new event is captured only after passing through IDLE again.
//  Queues
//   - Each queue is a FIFO with registered level and wrapping pointers (log2 DEPTH bits).
//   - "Has room" means level < DEPTH, or this queue is popped in the same cycle as the push.
//   - A simultaneous push and pop leaves the level unchanged.
//  Output stage (registered)
//   - Loads when out_valid=0 or (out_valid & out_ready).
//   - Back-to-back delivery is 1 event per cycle.
//   - Load source:
//     * both queues non-empty: the queue not named by rr_last; rr_last is updated to the granted queue;
//     * one queue non-empty: that queue;
//     * both empty: out_valid goes to 0.
//   - out_data and out_is_mouse hold stable while out_valid & !out_ready.
//  Latency
//   - kb_data_ready rises at edge N with both queues empty and the output empty:
//     out_valid=1 after edge N+1, and kb_retrieved is high during cycle N+1.
//  Drop counters saturate at 8'hFF; they never wrap.
// TESTING
//  1. Reset release; one keyboard event 16'h1234 -> kb_retrieved pulses 1 cycle; out_valid=1, out_is_mouse=0, out_data=16'h1234 two edges after data_ready rises.
//  2. out_ready=0; 5 keyboard events -> 1 in output reg, 4 queued (kb_level=4), 0 dropped; 6th event -> kb_drop_cnt=1 and kb_retrieved still pulses.
//  3. Queue K1,K2 and M1,M2 with out_ready=0, then hold out_ready=1 -> delivery order K1,M1,K2,M2 on 4 consecutive cycles.
//  4. kb_data_ready held high for 10 cycles after the ack (slow clear) -> exactly one capture, exactly one kb_retrieved pulse.
//  5. rst_n low mid-stream with kb_level=3, out_valid=1 -> all outputs and levels 0 immediately; normal capture resumes after release.
//  6. 300 mouse events with out_ready=0 -> ms_drop_cnt saturates at 255; ms_level=MS_DEPTH.

Source files
------------

// File: rtl/kbd_event_scheduler.sv
// Drains keyboard/mouse events from the Keyboard receiver's single-entry buffer
// into two FIFOs and delivers them round-robin to one valid/ready consumer.
module kbd_event_scheduler #(
  parameter int unsigned KB_DEPTH = 4,
  parameter int unsigned MS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kb_data_ready,
  input  logic        kb_is_mouse,
  input  logic [15:0] kb_data,
  output logic        kb_retrieved,
  output logic        out_valid,
  output logic        out_is_mouse,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [2:0]  kb_level,
  output logic [2:0]  ms_level,
  output logic [7:0]  kb_drop_cnt,
  output logic [7:0]  ms_drop_cnt
);

  localparam int unsigned KB_AW = $clog2(KB_DEPTH);
  localparam int unsigned MS_AW = $clog2(MS_DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} cap_state_t;

  cap_state_t state, state_nxt;

  logic [15:0]      kb_mem [KB_DEPTH];
  logic [15:0]      ms_mem [MS_DEPTH];
  logic [KB_AW-1:0] kb_wr_ptr, kb_rd_ptr;
  logic [MS_AW-1:0] ms_wr_ptr, ms_rd_ptr;
  logic             rr_last;

  logic capture, load;
  logic kb_pop, ms_pop, kb_push, ms_push, kb_drop, ms_drop;
  logic kb_room, ms_room, kb_nonempty, ms_nonempty;

  // Capture FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (kb_data_ready) state_nxt = ACK;
      ACK:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!kb_data_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    kb_retrieved = (state == ACK);
  end

  // Arbitration: grant the queue not named by rr_last when both have data
  assign kb_nonempty = (kb_level != 3'd0);
  assign ms_nonempty = (ms_level != 3'd0);
  assign load        = !out_valid || out_ready;
  assign kb_pop      = load && kb_nonempty && (!ms_nonempty || rr_last);
  assign ms_pop      = load && ms_nonempty && !kb_pop;

  // A full queue still accepts when it is popped in the same cycle
  assign kb_room = (kb_level < 3'(KB_DEPTH)) || kb_pop;
  assign ms_room = (ms_level < 3'(MS_DEPTH)) || ms_pop;

  assign capture = (state == IDLE) && kb_data_ready;
  assign kb_push = capture && !kb_is_mouse && kb_room;
  assign ms_push = capture &&  kb_is_mouse && ms_room;
  assign kb_drop = capture && !kb_is_mouse && !kb_room;
  assign ms_drop = capture &&  kb_is_mouse && !ms_room;

  always_ff @(posedge clk) begin
    if (kb_push) kb_mem[kb_wr_ptr] <= kb_data;
    if (ms_push) ms_mem[ms_wr_ptr] <= kb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_wr_ptr   <= '0;
      kb_rd_ptr   <= '0;
      kb_level    <= '0;
      kb_drop_cnt <= '0;
    end else begin
      if (kb_push) kb_wr_ptr <= kb_wr_ptr + KB_AW'(1);
      if (kb_pop)  kb_rd_ptr <= kb_rd_ptr + KB_AW'(1);
      case ({kb_push, kb_pop})
        2'b10:   kb_level <= kb_level + 3'd1;
        2'b01:   kb_level <= kb_level - 3'd1;
        default: kb_level <= kb_level;
      endcase
      if (kb_drop && kb_drop_cnt != 8'hFF) kb_drop_cnt <= kb_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_wr_ptr   <= '0;
      ms_rd_ptr   <= '0;
      ms_level    <= '0;
      ms_drop_cnt <= '0;
    end else begin
      if (ms_push) ms_wr_ptr <= ms_wr_ptr + MS_AW'(1);
      if (ms_pop)  ms_rd_ptr <= ms_rd_ptr + MS_AW'(1);
      case ({ms_push, ms_pop})
        2'b10:   ms_level <= ms_level + 3'd1;
        2'b01:   ms_level <= ms_level - 3'd1;
        default: ms_level <= ms_level;
      endcase
      if (ms_drop && ms_drop_cnt != 8'hFF) ms_drop_cnt <= ms_drop_cnt + 8'd1;
    end
  end

  // Output register; rr_last follows every grant so alternation holds after a lone grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_is_mouse <= 1'b0;
      out_data     <= '0;
      rr_last      <= 1'b1;
    end else if (load) begin
      if (kb_pop) begin
        out_valid    <= 1'b1;
        out_is_mouse <= 1'b0;
        out_data     <= kb_mem[kb_rd_ptr];
        rr_last      <= 1'b0;
      end else if (ms_pop) begin
        out_valid    <= 1'b1;
        out_is_mouse <= 1'b1;
        out_data     <= ms_mem[ms_rd_ptr];
        rr_last      <= 1'b1;
      end else begin
        out_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_event_scheduler.sv
// Directed bench for kbd_event_scheduler: event table with expected levels/drops,
// expected drain order, plus hand sequences for latency, slow clear, reset and saturation.
module tb_kbd_event_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kb_data_ready = 1'b0;
  logic        kb_is_mouse = 1'b0;
  logic [15:0] kb_data = '0;
  logic        kb_retrieved;
  logic        out_valid, out_is_mouse;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic [2:0]  kb_level, ms_level;
  logic [7:0]  kb_drop_cnt, ms_drop_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  kbd_event_scheduler #(.KB_DEPTH(4), .MS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .kb_data_ready(kb_data_ready), .kb_is_mouse(kb_is_mouse), .kb_data(kb_data),
    .kb_retrieved(kb_retrieved),
    .out_valid(out_valid), .out_is_mouse(out_is_mouse), .out_data(out_data),
    .out_ready(out_ready),
    .kb_level(kb_level), .ms_level(ms_level),
    .kb_drop_cnt(kb_drop_cnt), .ms_drop_cnt(ms_drop_cnt)
  );

  typedef struct {
    logic        is_mouse;
    logic [15:0] data;
    logic [2:0]  exp_kb_level;
    logic [2:0]  exp_ms_level;
    logic [7:0]  exp_kb_drop;
    logic [7:0]  exp_ms_drop;
  } ev_vec_t;

  typedef struct {
    logic        is_mouse;
    logic [15:0] data;
  } out_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    kb_data_ready = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Keyboard model: assert data_ready, wait for the ack, clear one cycle later
  task automatic send_event(input logic is_mouse, input logic [15:0] data);
    int unsigned waited;
    @(negedge clk);
    kb_data_ready = 1'b1;
    kb_is_mouse = is_mouse;
    kb_data = data;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!kb_retrieved && waited < 10);
    if (!kb_retrieved) check("ack_timeout", 32'(waited), 32'd1);
    @(negedge clk);
    kb_data_ready = 1'b0;
    @(negedge clk);
  endtask

  ev_vec_t  evs [11];
  out_vec_t drain [9];

  initial begin
    int unsigned pulses;

    // 1: reset values and first-event latency
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_kb_retrieved", 32'(kb_retrieved), 32'd0);
    check("rst_levels", 32'({kb_level, ms_level}), 32'd0);
    check("rst_drops", 32'({kb_drop_cnt, ms_drop_cnt}), 32'd0);
    kb_data_ready = 1'b1; kb_is_mouse = 1'b0; kb_data = 16'h1234;
    @(negedge clk);
    check("lat_retrieved_n1", 32'(kb_retrieved), 32'd1);
    check("lat_valid_n1", 32'(out_valid), 32'd0);
    kb_data_ready = 1'b0;
    @(negedge clk);
    check("lat_retrieved_n2", 32'(kb_retrieved), 32'd0);
    check("lat_valid_n2", 32'(out_valid), 32'd1);
    check("lat_is_mouse", 32'(out_is_mouse), 32'd0);
    check("lat_data", 32'(out_data), 32'h1234);

    // 2/3: fill, overflow, then drain in round-robin order
    evs[0]  = '{1'b0, 16'h1111, 3'd0, 3'd0, 8'd0, 8'd0};
    evs[1]  = '{1'b0, 16'h3333, 3'd1, 3'd0, 8'd0, 8'd0};
    evs[2]  = '{1'b0, 16'h4444, 3'd2, 3'd0, 8'd0, 8'd0};
    evs[3]  = '{1'b1, 16'h2222, 3'd2, 3'd1, 8'd0, 8'd0};
    evs[4]  = '{1'b0, 16'h5555, 3'd3, 3'd1, 8'd0, 8'd0};
    evs[5]  = '{1'b0, 16'h6666, 3'd4, 3'd1, 8'd0, 8'd0};
    evs[6]  = '{1'b0, 16'hAAAA, 3'd4, 3'd1, 8'd1, 8'd0};
    evs[7]  = '{1'b1, 16'h7777, 3'd4, 3'd2, 8'd1, 8'd0};
    evs[8]  = '{1'b1, 16'h8888, 3'd4, 3'd3, 8'd1, 8'd0};
    evs[9]  = '{1'b1, 16'h9999, 3'd4, 3'd4, 8'd1, 8'd0};
    evs[10] = '{1'b1, 16'hBBBB, 3'd4, 3'd4, 8'd1, 8'd1};
    drain[0] = '{1'b0, 16'h1111};
    drain[1] = '{1'b1, 16'h2222};
    drain[2] = '{1'b0, 16'h3333};
    drain[3] = '{1'b1, 16'h7777};
    drain[4] = '{1'b0, 16'h4444};
    drain[5] = '{1'b1, 16'h8888};
    drain[6] = '{1'b0, 16'h5555};
    drain[7] = '{1'b1, 16'h9999};
    drain[8] = '{1'b0, 16'h6666};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_event(evs[i].is_mouse, evs[i].data);
      check($sformatf("tbl%0d_kb_level", i), 32'(kb_level), 32'(evs[i].exp_kb_level));
      check($sformatf("tbl%0d_ms_level", i), 32'(ms_level), 32'(evs[i].exp_ms_level));
      check($sformatf("tbl%0d_kb_drop", i), 32'(kb_drop_cnt), 32'(evs[i].exp_kb_drop));
      check($sformatf("tbl%0d_ms_drop", i), 32'(ms_drop_cnt), 32'(evs[i].exp_ms_drop));
      check($sformatf("tbl%0d_hold", i), 32'({out_valid, out_data}), {15'd0, 1'b1, 16'h1111});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("drain%0d", i), 32'({out_valid, out_is_mouse, out_data}),
            {14'd0, 1'b1, drain[i].is_mouse, drain[i].data});
      @(negedge clk);
    end
    check("drain_empty_valid", 32'(out_valid), 32'd0);
    check("drain_empty_levels", 32'({kb_level, ms_level}), 32'd0);

    // 4: data_ready held high long after the ack
    do_reset();
    kb_data_ready = 1'b1; kb_is_mouse = 1'b0; kb_data = 16'h00C4;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (kb_retrieved) pulses++;
    end
    kb_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("slow_pulses", pulses, 32'd1);
    check("slow_kb_level", 32'(kb_level), 32'd0);
    check("slow_out", 32'({out_valid, out_data}), {15'd0, 1'b1, 16'h00C4});

    // 5: asynchronous reset mid-stream, then normal capture
    do_reset();
    for (int i = 0; i < 4; i++) send_event(1'b0, 16'(16'h0500 + i));
    check("pre_rst_kb_level", 32'(kb_level), 32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'({out_valid, out_is_mouse, out_data}), 32'd0);
    check("mid_rst_levels", 32'({kb_level, ms_level, kb_retrieved}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_event(1'b1, 16'hBEEF);
    check("post_rst_out", 32'({out_valid, out_is_mouse, out_data}), {14'd0, 2'b11, 16'hBEEF});
    check("post_rst_levels", 32'({kb_level, ms_level}), 32'd0);

    // 6: mouse drop counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) send_event(1'b1, 16'(i));
    check("sat_ms_drop", 32'(ms_drop_cnt), 32'd255);
    check("sat_ms_level", 32'(ms_level), 32'd4);
    check("sat_kb_drop", 32'(kb_drop_cnt), 32'd0);
    check("sat_out", 32'({out_valid, out_is_mouse, out_data}), {14'd0, 2'b11, 16'h0000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
